vga_sync_receiver: RTL

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// Recovers hc/vc timing from asynchronous active-low VGA syncs, counting only on pix_en cycles,
// and verifies line/frame lengths before declaring lock.
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       err
);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HStart  = 10'(H_START);
  localparam logic [9:0] VStart  = 10'(V_START);
  localparam logic [9:0] HStop   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] VStop   = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] MaxCnt  = 10'h3FF;
  localparam logic [2:0] LockCnt = 3'(LOCK_FRAMES);

  logic       h_meta_q, h_sync_q, v_meta_q, v_sync_q;
  logic       h_hist_q, v_hist_q;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [2:0] good_q, good_d;
  state_e     state_q, state_d;
  logic       locked_q, locked_d, err_q, err_d, fs_q, fs_d;
  logic       h_fall, v_fall, line_err, frame_err;

  assign h_fall = pix_en & ~h_sync_q & h_hist_q;
  assign v_fall = pix_en & ~v_sync_q & v_hist_q;

  // Synchronizers reset to the idle (high) sync level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_meta_q <= 1'b1;
      h_sync_q <= 1'b1;
      v_meta_q <= 1'b1;
      v_sync_q <= 1'b1;
      h_hist_q <= 1'b1;
      v_hist_q <= 1'b1;
      hc_q     <= '0;
      vc_q     <= '0;
      good_q   <= '0;
      state_q  <= StSearch;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_meta_q <= hSync;
      h_sync_q <= h_meta_q;
      v_meta_q <= vSync;
      v_sync_q <= v_meta_q;
      if (pix_en) begin
        h_hist_q <= h_sync_q;
        v_hist_q <= v_sync_q;
      end
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      good_q   <= good_d;
      state_q  <= state_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      fs_q     <= fs_d;
    end
  end

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (h_fall) hc_d = '0;
      else if (hc_q != MaxCnt) hc_d = hc_q + 10'd1;
      if (v_fall) vc_d = '0;
      else if (h_fall && (vc_q != MaxCnt)) vc_d = vc_q + 10'd1;
    end
  end

  // Checks use the counts before this cycle's load.
  assign line_err  = pix_en & ((h_fall & (hc_q != HLast)) | (~h_fall & (hc_q == HLast)));
  assign frame_err = v_fall & (vc_q != VLast);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    fs_d     = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (v_fall) begin
          state_d = StTrack;
          good_d  = '0;
          fs_d    = 1'b1;
        end
      end
      StTrack, StLocked: begin
        if (line_err || frame_err) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          good_d   = '0;
          state_d  = StSearch;
        end else if (v_fall) begin
          fs_d = 1'b1;
          if (state_q == StTrack) begin
            good_d = good_q + 3'd1;
            if (good_d >= LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  assign active = (hc_q >= HStart) && (hc_q < HStop) && (vc_q >= VStart) && (vc_q < VStop);
  assign px_x   = active ? hc_q - HStart : '0;
  assign px_y   = active ? vc_q - VStart : '0;

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign frame_start = fs_q;

endmodule
